// File: rtl/frame_comparator_if.sv
// RAM-side bus of the frame comparator: shared read port to RAM 1/2 and write port to RAM 3.
interface frame_comparator_if #(
    parameter int ADDR_W = 19
);
    logic [ADDR_W-1:0] rd_address;
    logic [23:0]       q1;
    logic [23:0]       q2;
    logic [ADDR_W-1:0] wr_address;
    logic              wren3;
    logic [23:0]       data3;

    modport master (
        output rd_address, wr_address, wren3, data3,
        input  q1, q2
    );

    modport slave (
        input  rd_address, wr_address, wren3, data3,
        output q1, q2
    );
endinterface

// File: rtl/frame_comparator.sv
// Sweeps RAM 1 and RAM 2 in lockstep, writes a per-pixel comparison image to RAM 3
// and counts mismatching pixels; start/busy/done handshake toward the controller.
module frame_comparator #(
    parameter int          PIXELS = 307200,
    parameter int          ADDR_W = 19,
    parameter int unsigned RD_LAT = 1,
    parameter logic [23:0] HILITE = 24'hFF0000
) (
    input  logic              clk50,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        threshold,
    frame_comparator_if.master ram,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] diff_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PIXELS - 1);

    logic [1:0]        state;
    logic [7:0]        thr_q;
    logic              vld       [RD_LAT];
    logic [ADDR_W-1:0] addr_pipe [RD_LAT];
    logic              mismatch;
    logic [23:0]       dimmed;

    function automatic logic chan_over(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] t);
        logic [8:0] d;
        d = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
        return d > {1'b0, t};
    endfunction

    always_comb begin
        mismatch = chan_over(ram.q1[23:16], ram.q2[23:16], thr_q)
                 | chan_over(ram.q1[15:8],  ram.q2[15:8],  thr_q)
                 | chan_over(ram.q1[7:0],   ram.q2[7:0],   thr_q);
        dimmed   = {1'b0, ram.q1[23:17], 1'b0, ram.q1[15:9], 1'b0, ram.q1[7:1]};
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            thr_q          <= '0;
            ram.rd_address <= '0;
            ram.wr_address <= '0;
            ram.wren3      <= 1'b0;
            ram.data3      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            diff_count     <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                vld[i]       <= 1'b0;
                addr_pipe[i] <= '0;
            end
        end else begin
            // Address travels alongside the read so the write lands on the issued pixel.
            vld[0]       <= (state == S_RUN);
            addr_pipe[0] <= ram.rd_address;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld[i]       <= vld[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end

            ram.wren3 <= vld[RD_LAT-1];
            if (vld[RD_LAT-1]) begin
                ram.wr_address <= addr_pipe[RD_LAT-1];
                ram.data3      <= mismatch ? HILITE : dimmed;
                if (mismatch) begin
                    diff_count <= diff_count + ADDR_W'(1);
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state          <= S_RUN;
                        thr_q          <= threshold;
                        diff_count     <= '0;
                        done           <= 1'b0;
                        busy           <= 1'b1;
                        ram.rd_address <= '0;
                    end
                end
                S_RUN: begin
                    if (ram.rd_address == LAST) begin
                        state <= S_DRAIN;
                    end else begin
                        ram.rd_address <= ram.rd_address + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    // Exit on the edge that retires the final write.
                    if (ram.wren3 && (ram.wr_address == LAST)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_comparator.sv
// Directed bench for frame_comparator: two instances (read latency 1 and 2) on a 16-pixel frame.
module tb_frame_comparator;

    localparam int AW   = 19;
    localparam int NPIX = 16;
    localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

    logic clk50 = 1'b0;
    always #5 clk50 = ~clk50;

    logic          reset_n;
    logic          start;
    logic [7:0]    threshold;
    logic          busy1, done1, busy2, done2;
    logic [AW-1:0] cnt1, cnt2;

    frame_comparator_if #(.ADDR_W(AW)) bus1 ();
    frame_comparator_if #(.ADDR_W(AW)) bus2 ();

    frame_comparator #(.PIXELS(NPIX), .ADDR_W(AW), .RD_LAT(1), .HILITE(24'hFF0000)) u_dut1 (
        .clk50(clk50), .reset_n(reset_n), .start(start), .threshold(threshold),
        .ram(bus1), .busy(busy1), .done(done1), .diff_count(cnt1)
    );

    frame_comparator #(.PIXELS(NPIX), .ADDR_W(AW), .RD_LAT(2), .HILITE(24'hFF0000)) u_dut2 (
        .clk50(clk50), .reset_n(reset_n), .start(start), .threshold(threshold),
        .ram(bus2), .busy(busy2), .done(done2), .diff_count(cnt2)
    );

    int checks = 0;
    int errors = 0;

    logic [23:0]   p1_def, p2_def, p1_hot, p2_hot;
    logic [AW-1:0] hot_addr;

    function automatic logic [23:0] img1(input logic [AW-1:0] a);
        return (a == hot_addr) ? p1_hot : p1_def;
    endfunction

    function automatic logic [23:0] img2(input logic [AW-1:0] a);
        return (a == hot_addr) ? p2_hot : p2_def;
    endfunction

    logic [23:0] s1, s2;
    always @(posedge clk50) begin
        bus1.q1 <= img1(bus1.rd_address);
        bus1.q2 <= img2(bus1.rd_address);
        s1      <= img1(bus2.rd_address);
        s2      <= img2(bus2.rd_address);
        bus2.q1 <= s1;
        bus2.q2 <= s2;
    end

    logic          w_en   [2];
    logic [AW-1:0] w_addr [2];
    logic [23:0]   w_data [2];
    logic [AW-1:0] r_addr [2];
    logic          bsy    [2];
    logic          dn     [2];
    logic [AW-1:0] dcnt   [2];

    assign w_en[0]   = bus1.wren3;      assign w_en[1]   = bus2.wren3;
    assign w_addr[0] = bus1.wr_address; assign w_addr[1] = bus2.wr_address;
    assign w_data[0] = bus1.data3;      assign w_data[1] = bus2.data3;
    assign r_addr[0] = bus1.rd_address; assign r_addr[1] = bus2.rd_address;
    assign bsy[0]    = busy1;           assign bsy[1]    = busy2;
    assign dn[0]     = done1;           assign dn[1]     = done2;
    assign dcnt[0]   = cnt1;            assign dcnt[1]   = cnt2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s/dut%0d/rd_address", name, k), 32'(r_addr[k]), 32'd0);
            check($sformatf("%s/dut%0d/wr_address", name, k), 32'(w_addr[k]), 32'd0);
            check($sformatf("%s/dut%0d/wren3", name, k),      32'(w_en[k]),   32'd0);
            check($sformatf("%s/dut%0d/data3", name, k),      32'(w_data[k]), 32'd0);
            check($sformatf("%s/dut%0d/busy", name, k),       32'(bsy[k]),    32'd0);
            check($sformatf("%s/dut%0d/done", name, k),       32'(dn[k]),     32'd0);
            check($sformatf("%s/dut%0d/diff_count", name, k), 32'(dcnt[k]),  32'd0);
        end
    endtask

    // mid_at >= 0 re-pulses start (threshold 255) when the read address reaches mid_at;
    // late_start pulses start on the edge that retires dut0's final write.
    task automatic run_pass(input string name, input logic [7:0] thr,
                            input logic [23:0] exp_norm, input logic [23:0] exp_hot,
                            input int exp_cnt, input int mid_at, input bit late_start);
        int nwr[2], first[2], last[2], done_at[2];
        logic [23:0] exp_d;
        for (int k = 0; k < 2; k++) begin
            nwr[k] = 0; first[k] = -1; last[k] = -1; done_at[k] = -1;
        end
        @(posedge clk50);
        #1 start = 1'b1;
        threshold = thr;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk50);
            #1 start = 1'b0;
            @(negedge clk50);
            for (int k = 0; k < 2; k++) begin
                if (cyc == 1) begin
                    check($sformatf("%s/dut%0d/busy_early", name, k), 32'(bsy[k]), 32'd1);
                    check($sformatf("%s/dut%0d/done_early", name, k), 32'(dn[k]), 32'd0);
                end
                if (w_en[k]) begin
                    if (nwr[k] == 0) first[k] = cyc;
                    last[k] = cyc;
                    exp_d = (w_addr[k] == hot_addr) ? exp_hot : exp_norm;
                    check($sformatf("%s/dut%0d/wr_address", name, k), 32'(w_addr[k]), 32'(nwr[k]));
                    check($sformatf("%s/dut%0d/data3@%0d", name, k, w_addr[k]), 32'(w_data[k]), 32'(exp_d));
                    nwr[k]++;
                end
                if (dn[k] && done_at[k] < 0) done_at[k] = cyc;
            end
            if (mid_at >= 0 && r_addr[0] == AW'(mid_at) && cyc < NPIX) begin
                start = 1'b1;
                threshold = 8'hFF;
            end
            if (late_start && w_en[0] && w_addr[0] == LAST) start = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s/dut%0d/writes", name, k),     32'(nwr[k]), 32'(NPIX));
            check($sformatf("%s/dut%0d/first_wr", name, k),   32'(first[k]), 32'(k + 3));
            check($sformatf("%s/dut%0d/span", name, k),       32'(last[k] - first[k] + 1), 32'(NPIX));
            check($sformatf("%s/dut%0d/done_edge", name, k),  32'(done_at[k]), 32'(last[k] + 1));
            check($sformatf("%s/dut%0d/busy_end", name, k),   32'(bsy[k]), 32'd0);
            check($sformatf("%s/dut%0d/done_end", name, k),   32'(dn[k]), 32'd1);
            check($sformatf("%s/dut%0d/diff_count", name, k), 32'(dcnt[k]), 32'(exp_cnt));
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        threshold = 8'h00;
        p1_def    = 24'h80C040;
        p2_def    = 24'h80C040;
        p1_hot    = 24'h80C040;
        p2_hot    = 24'h80C040;
        hot_addr  = AW'(10);
        #23;
        check_all_zero("reset");
        @(negedge clk50);
        reset_n = 1'b1;

        // Identical frames; also a start landing on the DONE-entry edge must be ignored.
        run_pass("ident", 8'd0, 24'h406020, 24'h406020, 0, -1, 1'b1);

        // Green differs by 9 at pixel 10.
        p2_hot = 24'h80C940;
        run_pass("g9_t8", 8'd8, 24'h406020, 24'hFF0000, 1, -1, 1'b0);
        run_pass("g9_t9", 8'd9, 24'h406020, 24'h406020, 0, -1, 1'b0);
        run_pass("mid_start", 8'd8, 24'h406020, 24'hFF0000, 1, 5, 1'b0);

        // Blue 10 vs 250 at pixel 3: distance 240 in either direction.
        hot_addr = AW'(3);
        p1_hot   = 24'h80C00A;
        p2_hot   = 24'h80C0FA;
        run_pass("absdir", 8'd200, 24'h406020, 24'hFF0000, 1, -1, 1'b0);
        run_pass("t255", 8'd255, 24'h406020, 24'h406005, 0, -1, 1'b0);

        // Asynchronous reset in the middle of a pass.
        begin
            bit hit;
            hit = 1'b0;
            @(posedge clk50);
            #1 start = 1'b1;
            threshold = 8'd200;
            for (int cyc = 0; cyc < 30 && !hit; cyc++) begin
                @(posedge clk50);
                #1 start = 1'b0;
                @(negedge clk50);
                if (r_addr[0] == AW'(9)) hit = 1'b1;
            end
            check("midreset/reached_addr9", 32'(hit), 32'd1);
            check("midreset/count_before", 32'(cnt1), 32'd1);
            #2 reset_n = 1'b0;
            #1;
            check_all_zero("midreset");
            @(posedge clk50);
            @(posedge clk50);
            @(negedge clk50);
            reset_n = 1'b1;
        end
        run_pass("after_rst", 8'd200, 24'h406020, 24'hFF0000, 1, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_comparator.md
Name: frame_comparator

Overview:
- Sequencer upstream of the drawer stage: walks both input frame RAMs (image 1, image 2) over all 640x480 pixels and writes a per-pixel comparison image into result RAM 3.
- Counts mismatching pixels; the drawer then displays RAM 3.
- Replaces the bench-driven address sweep with wren3 held high; start/busy/done handshake toward the controlling logic.

Parameters:
- PIXELS, 307200, pixels per frame; addresses 0..PIXELS-1.
- ADDR_W, 19, address and counter width.
- RD_LAT, 1, read latency of RAM 1/2 in clk50 cycles (q valid RD_LAT cycles after address).
- HILITE, 24'hFF0000, colour written for a mismatching pixel ({R,G,B}).

Ports:
- clk50  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a comparison pass.
- threshold  in  8  per-channel tolerance, sampled on accepted start.
- rd_address  out  ADDR_W  read address to RAM 1 and RAM 2.
- q1  in  24  RAM 1 read data {R[23:16],G[15:8],B[7:0]}.
- q2  in  24  RAM 2 read data, same packing.
- wr_address  out  ADDR_W  write address to RAM 3.
- wren3  out  1  write enable to RAM 3.
- data3  out  24  write data to RAM 3.
- busy  out  1  high from accepted start until last write done.
- done  out  1  high after a completed pass until next accepted start.
- diff_count  out  ADDR_W  number of mismatching pixels in last or current pass.

Behaviour:
- Reset (async, any time, incl. mid-pass): state IDLE; rd_address=0, wr_address=0, wren3=0, data3=0, busy=0, done=0, diff_count=0, pipeline valid bits cleared. No partial-pass recovery; RAM 3 content is left as-is.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE: start=1 -> RUN next cycle; threshold latched; diff_count<=0; done<=0; busy<=1; rd_address<=0.
- start while busy (RUN/DRAIN) ignored; no effect on counters or latched threshold.
- RUN: one read issued per cycle; rd_address increments by 1 each cycle from 0; after issuing PIXELS-1 -> DRAIN (rd_address holds PIXELS-1).
- Pipeline: read issued at cycle t; q1/q2 consumed at t+RD_LAT; comparison result registered so wren3/data3/wr_address valid at t+RD_LAT+1, with wr_address = address issued at t.
- DRAIN: waits until the write for address PIXELS-1 is done (RD_LAT+1 cycles after last issue) -> DONE; busy<=0, done<=1 same edge the last write retires.
- Total wren3-high cycles per pass = PIXELS exactly, contiguous; first write at RD_LAT+2 cycles after the start edge.
- Compare: per channel d = |q1.ch - q2.ch| (8-bit unsigned, no wrap: compute in 9 bits). Mismatch iff any channel d > threshold (strict).
- data3 = HILITE on mismatch; else {q1.R>>1, q1.G>>1, q1.B>>1} (q1 dimmed by half).
- diff_count increments on each mismatching write; max PIXELS fits in ADDR_W, no saturation needed. Value stable in DONE.
- threshold=255: never mismatch. threshold=0: any nonzero channel difference mismatches.
- start in same cycle as DONE entry: not accepted (state still DRAIN); accepted any cycle in DONE/IDLE.

Test Plan:
- Identical frames (q1=q2=24'h80C040 all pixels), threshold 0, start -> 307200 wren3 pulses, data3=24'h406020 each, diff_count=0, done=1, busy=0.
- RAM 2 differs at addr 1000 only, G +9, threshold 8 -> single write data3=24'hFF0000 at wr_address 1000, diff_count=1; repeat with threshold 9 -> diff_count=0.
- Check abs direction: q1.B=10, q2.B=250, threshold 200 -> mismatch (d=240), no wrap-around false match.
- Latency: PIXELS=16, RD_LAT=1 and 2 -> first wren3 at start+RD_LAT+2 cycles, wr_address 0..15 contiguous, done asserted same edge as final write retires.
- start pulsed at pixel 5 of a running pass -> ignored; pass completes with exactly PIXELS writes, diff_count unchanged by the extra pulse.
- reset_n low at address 500 mid-pass -> all outputs 0 immediately (async); after release, new start runs a full clean pass from address 0.
